soc_cpu_debug_cmd_queue_sysclk: RTL
===================================

// Module: soc_cpu_debug_cmd_queue_sysclk
// PURPOSE
// System-clock side of the Nios II JTAG debug slave, next generation: resynchronises the
// update-IR/update-DR strobes arriving from the TCK domain, captures the scanned data register,
// and queues each completed scan as a command for the OCI core. It replaces fixed take_action_*
// wires with a parametrised IR decode, a DEPTH-entry command FIFO with a valid/ready handshake,
// and one-hot action/no-action pulses per instruction. It sits between the virtual-JTAG TCK
// logic and the OCI break/ocimem/trace controllers.
// PARAMETERS
// DR_W         38  width of scanned data register sr / cmd_jdo
// IR_W          2  virtual-JTAG IR width; N_CH = 2**IR_W decoded channels
// DEPTH         4  command FIFO entries (power of 2, >= 2)
// SYNC_STAGES   2  synchroniser flops on vs_udr / vs_uir (>= 2)
// ACT_BIT      37  bit of captured sr that selects action (1) vs no-action (0)
// PORTS
// clk             in   1          system clock
// reset_n         in   1          asynchronous active-low reset
// vs_uir          in   1          update-IR level from TCK domain (async)
// vs_udr          in   1          update-DR level from TCK domain (async)
// ir_in           in   IR_W       IR value (quasi-static, stable around vs_uir)
// sr              in   DR_W       scan register (quasi-static, stable around vs_udr)
// cmd_ready       in   1          consumer accepts head command
// ovf_clr         in   1          clears sticky overflow
// cmd_valid       out  1          FIFO non-empty
// cmd_ir          out  IR_W       head command instruction
// cmd_jdo         out  DR_W       head command data (jdo)
// cmd_action      out  1          head command action flag (= captured sr[ACT_BIT])
// take_action     out  N_CH       one-hot pulse on pop with action=1, index = cmd_ir
// take_no_action  out  N_CH       one-hot pulse on pop with action=0, index = cmd_ir
// fifo_level      out  log2(DEPTH)+1  entries held
// overflow        out  1          sticky: a command was dropped on full
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, ir_reg 0, sync chains 0, edge detector disarmed.
// - Edge detector arms SYNC_STAGES+1 cycles after reset release; a strobe already high at
//   release produces no event.
// - uir_evt / udr_evt: single-cycle pulse on synchronised 0->1, SYNC_STAGES+1 clk after the
//   input rises. Held-high strobe gives exactly one event; 1->0 gives none.
// - uir_evt: ir_reg <= ir_in. udr_evt: push {ir_reg, sr[ACT_BIT], sr} in the same cycle.
//   Simultaneous uir_evt+udr_evt: push uses the OLD ir_reg; ir_reg updates after.
// - FIFO show-ahead: cmd_* reflect head whenever cmd_valid=1; cmd_* are 0 when empty.
//   First push to empty FIFO: cmd_valid high the next cycle (no fall-through).
// - Pop = cmd_valid & cmd_ready. In the pop cycle, take_action[cmd_ir] or take_no_action[cmd_ir]
//   is high, combinationally from head (0 otherwise; never both; at most one bit set).
// - Push while full and no pop: command dropped, overflow <= 1, FIFO contents unchanged.
//   Push+pop while full: both performed, no overflow. Push+pop while empty: push only.
// - overflow stays 1 until ovf_clr; ovf_clr concurrent with a dropping push leaves it 1.
// - fifo_level: +1 on push, -1 on pop, unchanged on push+pop; range 0..DEPTH.
// - Pointers wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
// - Async reset mid-operation discards queued commands and disarms edge detection; no pulse on
//   take_action/take_no_action during or in the first cycle after reset.
// TESTING
// - IR: vs_uir 0->1 with ir_in=2, then vs_udr 0->1 with sr[37]=1, sr[31:0]=32'hCAFE_F00D,
//   cmd_ready=1 -> cmd_valid at udr+SYNC_STAGES+2, cmd_ir=2, take_action=4'b0100 one cycle.
// - sr[37]=0, ir=1, cmd_ready=1 -> take_no_action=4'b0010, take_action=0, cmd_jdo=sr.
// - cmd_ready=0, 5 scans (DEPTH=4) -> fifo_level=4, overflow=1, drain yields scans 1..4 in order;
//   ovf_clr -> overflow=0.
// - FIFO full, 6th udr coincident with cmd_ready=1 -> no overflow, level stays 4, scan 6 last out.
// - vs_uir and vs_udr rise same cycle with ir_in=3, ir_reg=0 -> queued cmd_ir=0; next scan uses 3.
// - vs_udr held high across reset release -> no command queued; 3 queued then reset_n low ->
//   cmd_valid=0, fifo_level=0, no action pulses.

Source files
------------

// File: rtl/soc_cpu_debug_cmd_queue_sysclk.sv
// System-clock side of the JTAG debug slave: resynchronises update strobes
// and queues each completed DR scan as a command for the OCI core.
module soc_cpu_debug_cmd_queue_sysclk_strb #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arm,
    input  logic strb,
    output logic evt
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              evt_q;

    // prev_q tracks the synchronised level even while disarmed, so a strobe
    // already high at arming time never looks like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strb};
            prev_q <= sync_q[STAGES-1];
            evt_q  <= arm & sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign evt = evt_q;

endmodule

module soc_cpu_debug_cmd_queue_sysclk #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 37,
    parameter int N_CH        = 2 ** IR_W,
    parameter int LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vs_uir,
    input  logic             vs_udr,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [DR_W-1:0]  sr,
    input  logic             cmd_ready,
    input  logic             ovf_clr,
    output logic             cmd_valid,
    output logic [IR_W-1:0]  cmd_ir,
    output logic [DR_W-1:0]  cmd_jdo,
    output logic             cmd_action,
    output logic [N_CH-1:0]  take_action,
    output logic [N_CH-1:0]  take_no_action,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int E_W = IR_W + 1 + DR_W;
    localparam int CW  = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]    ARM_N = CW'(SYNC_STAGES + 1);
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);

    logic [CW-1:0]    arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             uir_evt, udr_evt;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [E_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             ovf_q, ovf_d;
    logic             full, empty;
    logic             push, pop, drop;
    logic [E_W-1:0]   head;
    logic [E_W-1:0]   wr_ent;
    logic [N_CH-1:0]  onehot;

    assign armed     = (arm_cnt_q == ARM_N);
    assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);

    soc_cpu_debug_cmd_queue_sysclk_strb #(
        .STAGES (SYNC_STAGES)
    ) u_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (armed),
        .strb    (vs_uir),
        .evt     (uir_evt)
    );

    soc_cpu_debug_cmd_queue_sysclk_strb #(
        .STAGES (SYNC_STAGES)
    ) u_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .arm     (armed),
        .strb    (vs_udr),
        .evt     (udr_evt)
    );

    assign full   = (lvl_q == FULL);
    assign empty  = (lvl_q == '0);
    assign pop    = ~empty & cmd_ready;
    assign push   = udr_evt & (~full | pop);
    assign drop   = udr_evt & full & ~pop;
    // Non-blocking update means a same-cycle IR update lands after this push.
    assign wr_ent = {ir_q, sr[ACT_BIT], sr};
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        ir_d     = ir_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        ovf_d    = ovf_q;
        if (uir_evt) begin
            ir_d = ir_in;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            lvl_d = lvl_q + LVL_W'(1);
        end else if (pop && !push) begin
            lvl_d = lvl_q - LVL_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            ir_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lvl_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            ir_q      <= ir_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lvl_q     <= lvl_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    always_comb begin
        cmd_valid  = ~empty;
        cmd_ir     = '0;
        cmd_action = 1'b0;
        cmd_jdo    = '0;
        if (!empty) begin
            {cmd_ir, cmd_action, cmd_jdo} = head;
        end
    end

    assign onehot         = N_CH'(1) << cmd_ir;
    assign take_action    = (pop && cmd_action)  ? onehot : '0;
    assign take_no_action = (pop && !cmd_action) ? onehot : '0;
    assign fifo_level     = lvl_q;
    assign overflow       = ovf_q;

endmodule
